// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: six-state one-hot ring counter plus fixed microcode
// decoder producing the per-cycle control word for the datapath.
module sap1_control_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    output logic [5:0] T,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       Er,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Lb,
    output logic       Lo,
    output logic       Eu,
    output logic       Add,
    output logic       Sub,
    output logic       AndOp,
    output logic       OrOp,
    output logic       XorOp,
    output logic       NotOp,
    output logic       Hlt
);

    localparam logic [3:0] OpLda = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpAnd = 4'b0011;
    localparam logic [3:0] OpOr  = 4'b0100;
    localparam logic [3:0] OpXor = 4'b0101;
    localparam logic [3:0] OpNot = 4'b0110;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    typedef enum logic [5:0] {
        StT1 = 6'b000001,
        StT2 = 6'b000010,
        StT3 = 6'b000100,
        StT4 = 6'b001000,
        StT5 = 6'b010000,
        StT6 = 6'b100000
    } state_t;

    state_t state_q, state_d;
    logic   halted_q, halted_d;
    logic   is_lda, is_bin;

    assign is_lda = (opcode == OpLda);
    assign is_bin = (opcode >= OpAdd) && (opcode <= OpXor);
    assign T      = state_q;

    // Ring state and halt flag; clr resets immediately without a clock edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= StT1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Ring advance; HLT at T4 freezes the ring at T4 until clr.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (state_q)
                StT1:    state_d = StT2;
                StT2:    state_d = StT3;
                StT3:    state_d = StT4;
                StT4: begin
                    if (opcode == OpHlt) begin
                        halted_d = 1'b1;
                    end else begin
                        state_d = StT5;
                    end
                end
                StT5:    state_d = StT6;
                StT6:    state_d = StT1;
                default: state_d = StT1;
            endcase
        end
    end

    // Microcode decode of (state, opcode, halted) into the control word.
    always_comb begin
        Cp    = 1'b0;
        Ep    = 1'b0;
        Lm    = 1'b0;
        Er    = 1'b0;
        Li    = 1'b0;
        Ei    = 1'b0;
        La    = 1'b0;
        Ea    = 1'b0;
        Lb    = 1'b0;
        Lo    = 1'b0;
        Eu    = 1'b0;
        Add   = 1'b0;
        Sub   = 1'b0;
        AndOp = 1'b0;
        OrOp  = 1'b0;
        XorOp = 1'b0;
        NotOp = 1'b0;
        Hlt   = 1'b0;
        if (halted_q) begin
            Hlt = 1'b1;
        end else begin
            case (state_q)
                StT1: begin
                    Ep = 1'b1;
                    Lm = 1'b1;
                end
                StT2: Cp = 1'b1;
                StT3: begin
                    Er = 1'b1;
                    Li = 1'b1;
                end
                StT4: begin
                    if (is_lda || is_bin) begin
                        Ei = 1'b1;
                        Lm = 1'b1;
                    end else if (opcode == OpNot) begin
                        Eu    = 1'b1;
                        NotOp = 1'b1;
                        La    = 1'b1;
                    end else if (opcode == OpOut) begin
                        Ea = 1'b1;
                        Lo = 1'b1;
                    end else if (opcode == OpHlt) begin
                        Hlt = 1'b1;
                    end
                end
                StT5: begin
                    if (is_lda) begin
                        Er = 1'b1;
                        La = 1'b1;
                    end else if (is_bin) begin
                        Er = 1'b1;
                        Lb = 1'b1;
                    end
                end
                StT6: begin
                    if (is_bin) begin
                        Eu = 1'b1;
                        La = 1'b1;
                        case (opcode)
                            OpAdd:   Add   = 1'b1;
                            OpSub:   Sub   = 1'b1;
                            OpAnd:   AndOp = 1'b1;
                            OpOr:    OrOp  = 1'b1;
                            OpXor:   XorOp = 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed self-checking bench for sap1_control_sequencer.
module tb_sap1_control_sequencer;

    logic       clk;
    logic       clr;
    logic [3:0] opcode;
    logic [5:0] T;
    logic Cp, Ep, Lm, Er, Li, Ei, La, Ea, Lb, Lo, Eu;
    logic Add, Sub, AndOp, OrOp, XorOp, NotOp, Hlt;
    logic [17:0] word;

    int checks = 0;
    int errors = 0;

    // Control word bit constants, Cp in the MSB down to Hlt in the LSB.
    localparam logic [17:0] WCp    = 18'h20000;
    localparam logic [17:0] WEp    = 18'h10000;
    localparam logic [17:0] WLm    = 18'h08000;
    localparam logic [17:0] WEr    = 18'h04000;
    localparam logic [17:0] WLi    = 18'h02000;
    localparam logic [17:0] WEi    = 18'h01000;
    localparam logic [17:0] WLa    = 18'h00800;
    localparam logic [17:0] WEa    = 18'h00400;
    localparam logic [17:0] WLb    = 18'h00200;
    localparam logic [17:0] WLo    = 18'h00100;
    localparam logic [17:0] WEu    = 18'h00080;
    localparam logic [17:0] WAdd   = 18'h00040;
    localparam logic [17:0] WSub   = 18'h00020;
    localparam logic [17:0] WAnd   = 18'h00010;
    localparam logic [17:0] WOr    = 18'h00008;
    localparam logic [17:0] WXor   = 18'h00004;
    localparam logic [17:0] WNot   = 18'h00002;
    localparam logic [17:0] WHlt   = 18'h00001;
    localparam logic [17:0] WNone  = 18'h00000;

    sap1_control_sequencer dut (
        .clk    (clk),
        .clr    (clr),
        .opcode (opcode),
        .T      (T),
        .Cp     (Cp),
        .Ep     (Ep),
        .Lm     (Lm),
        .Er     (Er),
        .Li     (Li),
        .Ei     (Ei),
        .La     (La),
        .Ea     (Ea),
        .Lb     (Lb),
        .Lo     (Lo),
        .Eu     (Eu),
        .Add    (Add),
        .Sub    (Sub),
        .AndOp  (AndOp),
        .OrOp   (OrOp),
        .XorOp  (XorOp),
        .NotOp  (NotOp),
        .Hlt    (Hlt)
    );

    assign word = {Cp, Ep, Lm, Er, Li, Ei, La, Ea, Lb, Lo, Eu,
                   Add, Sub, AndOp, OrOp, XorOp, NotOp, Hlt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Runs a full instruction starting in T1; checks T and word every cycle.
    task automatic run_instr(input string name, input logic [3:0] op,
                             input logic [17:0] w4, input logic [17:0] w5,
                             input logic [17:0] w6);
        logic [17:0] exp_w [6];
        logic [5:0]  exp_t;
        exp_w[0] = WEp | WLm;
        exp_w[1] = WCp;
        exp_w[2] = WEr | WLi;
        exp_w[3] = w4;
        exp_w[4] = w5;
        exp_w[5] = w6;
        opcode = op;
        for (int k = 0; k < 6; k++) begin
            exp_t = 6'b000001 << k;
            check($sformatf("%s T%0d state", name, k + 1), 32'(T), 32'(exp_t));
            check($sformatf("%s T%0d word", name, k + 1), 32'(word), 32'(exp_w[k]));
            step();
        end
        check($sformatf("%s wrap", name), 32'(T), 32'd1);
    endtask

    task automatic check_invariants(input int cyc);
        logic [4:0] bus;
        logic [4:0] sel;
        bus = {Ep, Er, Ei, Ea, Eu};
        sel = {Add, Sub, AndOp, OrOp, XorOp};
        check($sformatf("inv bus onehot cyc%0d", cyc), 32'($onehot0(bus)), 32'd1);
        check($sformatf("inv sel onehot cyc%0d", cyc), 32'($onehot0(sel)), 32'd1);
        check($sformatf("inv sel->Eu cyc%0d", cyc), 32'(!(|sel) || Eu), 32'd1);
        check($sformatf("inv Eu->La cyc%0d", cyc), 32'(!Eu || La), 32'd1);
    endtask

    initial begin
        logic [3:0] rop;
        clr    = 1'b1;
        opcode = 4'b0000;
        #12;
        check("reset state", 32'(T), 32'd1);
        check("reset word", 32'(word), 32'(WEp | WLm));
        clr = 1'b0;

        // First instruction after reset; T2 one edge after release.
        run_instr("ADD", 4'b0001, WEi | WLm, WEr | WLb, WEu | WLa | WAdd);
        run_instr("SUB", 4'b0010, WEi | WLm, WEr | WLb, WEu | WLa | WSub);
        run_instr("AND", 4'b0011, WEi | WLm, WEr | WLb, WEu | WLa | WAnd);
        run_instr("OR",  4'b0100, WEi | WLm, WEr | WLb, WEu | WLa | WOr);
        run_instr("XOR", 4'b0101, WEi | WLm, WEr | WLb, WEu | WLa | WXor);
        run_instr("LDA", 4'b0000, WEi | WLm, WEr | WLa, WNone);
        run_instr("NOT", 4'b0110, WEu | WNot | WLa, WNone, WNone);
        run_instr("OUT", 4'b1110, WEa | WLo, WNone, WNone);
        for (int op = 7; op <= 13; op++) begin
            run_instr($sformatf("NOP%0d", op), 4'(op), WNone, WNone, WNone);
        end

        // Asynchronous reset in the middle of T5 of an ADD.
        opcode = 4'b0001;
        for (int k = 0; k < 4; k++) step();
        check("midADD at T5", 32'(T), 32'h10);
        #1 clr = 1'b1;
        #1;
        check("async clr state", 32'(T), 32'd1);
        check("async clr word", 32'(word), 32'(WEp | WLm));
        clr = 1'b0;
        step();
        check("post clr T2", 32'(T), 32'h02);
        check("post clr Cp", 32'(word), 32'(WCp));
        for (int k = 0; k < 5; k++) step();
        check("post clr back T1", 32'(T), 32'h01);

        // Halt entry at T4 and persistence across opcode changes.
        opcode = 4'b1111;
        for (int k = 0; k < 3; k++) step();
        check("HLT T4 state", 32'(T), 32'h08);
        check("HLT T4 word", 32'(word), 32'(WHlt));
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 5) opcode = 4'b0001;
            if (k == 12) opcode = 4'b0110;
            check($sformatf("halted state c%0d", k), 32'(T), 32'h08);
            check($sformatf("halted word c%0d", k), 32'(word), 32'(WHlt));
        end
        #1 clr = 1'b1;
        #1 clr = 1'b0;
        check("unhalt state", 32'(T), 32'd1);
        check("unhalt word", 32'(word), 32'(WEp | WLm));
        step();
        check("unhalt advance", 32'(T), 32'h02);

        // Random opcodes (HLT excluded so the ring keeps moving).
        for (int c = 0; c < 10000; c++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'b1111) rop = 4'b0000;
            opcode = rop;
            #1;
            check_invariants(c);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
